// File: rtl/i2c_cfg_seq.sv
// I2C power-up configuration sequencer: walks a {dev_addr, reg, data} table and issues
// each entry as a 3-byte I2C write, with retries, delay entries and an end marker.
module i2c_cfg_seq #(
    parameter int CLK_FREQ  = 50000000,
    parameter int I2C_FREQ  = 20000,
    parameter int LUT_SIZE  = 64,
    parameter int ADDR_W    = 6,
    parameter int MAX_RETRY = 3
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSTART,
    output logic [ADDR_W-1:0] oROM_ADDR,
    input  logic [23:0]       iROM_DATA,
    output logic              I2C_SCLK,
    inout  wire               I2C_SDAT,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR,
    output logic [ADDR_W-1:0] oERR_INDEX
);

    localparam int TICK_DIV = (CLK_FREQ / (4 * I2C_FREQ) > 0) ? CLK_FREQ / (4 * I2C_FREQ) : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0]  LAST_INDEX  = ADDR_W'(LUT_SIZE - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DELAY, S_XFER, S_CHECK, S_NEXT, S_DONE, S_FAIL
    } state_e;

    typedef enum logic [1:0] {PH_START, PH_DATA, PH_STOP} phase_e;

    state_e              r_state;
    state_e              w_next;
    phase_e              r_phase;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic                w_tick;
    logic [ADDR_W-1:0]   r_index;
    logic [ADDR_W-1:0]   r_err_index;
    logic [23:0]         r_entry;
    logic [15:0]         r_delay;
    logic [RETRY_W-1:0]  r_retry;
    logic [1:0]          r_q;
    logic [26:0]         r_shift;
    logic [4:0]          r_bits_left;
    logic                r_nack;
    logic                r_scl;
    logic                r_sda_oe;
    logic                w_sda_in;
    logic                w_ack_slot;
    logic                w_xfer_end;
    logic                w_busy;
    logic                w_done;
    logic                w_err;

    // Free-running quarter-SCL-period tick.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: w_next = S_LATCH;
            S_LATCH: begin
                if (iROM_DATA[23:16] == 8'hFF) begin
                    w_next = S_DONE;
                end else if (iROM_DATA[23:16] == 8'hFE) begin
                    w_next = S_DELAY;
                end else begin
                    w_next = S_XFER;
                end
            end
            S_DELAY: if (r_delay == 16'd0) w_next = S_NEXT;
            S_XFER:  if (w_xfer_end) w_next = S_CHECK;
            S_CHECK: begin
                if (!r_nack) begin
                    w_next = S_NEXT;
                end else if (r_retry < RETRY_LIMIT) begin
                    w_next = S_XFER;
                end else begin
                    w_next = S_FAIL;
                end
            end
            S_NEXT:  w_next = (r_index == LAST_INDEX) ? S_DONE : S_FETCH;
            S_DONE,
            S_FAIL:  if (iSTART) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b1;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: w_busy = 1'b0;
            S_DONE: begin
                w_busy = 1'b0;
                w_done = 1'b1;
            end
            S_FAIL: begin
                w_busy = 1'b0;
                w_err  = 1'b1;
            end
            default: w_busy = 1'b1;
        endcase
    end

    // Sequencer datapath: table index, decoded entry, delay and retry counters.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_index     <= '0;
            r_err_index <= '0;
            r_entry     <= '0;
            r_delay     <= '0;
            r_retry     <= '0;
        end else begin
            case (r_state)
                S_LATCH: begin
                    r_entry <= iROM_DATA;
                    r_delay <= iROM_DATA[15:0];
                    r_retry <= '0;
                end
                S_DELAY: if (w_tick && r_delay != 16'd0) r_delay <= r_delay - 16'd1;
                S_CHECK: begin
                    if (r_nack && r_retry < RETRY_LIMIT) begin
                        r_retry <= r_retry + 1'b1;
                    end else if (r_nack) begin
                        r_err_index <= r_index;
                    end
                end
                S_NEXT: if (r_index != LAST_INDEX) r_index <= r_index + 1'b1;
                S_DONE,
                S_FAIL: if (iSTART) r_index <= '0;
                default: ;
            endcase
        end
    end

    // Ack slots sit after the 8th bit of each byte: 19, 10 and 1 bits remaining.
    assign w_ack_slot = (r_bits_left == 5'd19) || (r_bits_left == 5'd10) || (r_bits_left == 5'd1);
    assign w_xfer_end = (r_state == S_XFER) && w_tick && (r_phase == PH_STOP) && (r_q == 2'd2);
    assign w_sda_in   = I2C_SDAT;

    // Bit engine: START, 27 bit slots (3 x {8 data, ack}), STOP; four ticks per bit.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_scl       <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_phase     <= PH_START;
            r_q         <= '0;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_nack      <= 1'b0;
        end else if (r_state != S_XFER) begin
            r_scl    <= 1'b1;
            r_sda_oe <= 1'b0;
            r_phase  <= PH_START;
            r_q      <= '0;
        end else if (w_tick) begin
            case (r_phase)
                PH_START: begin
                    if (r_q == 2'd0) begin
                        r_sda_oe    <= 1'b1;
                        r_nack      <= 1'b0;
                        r_shift     <= {r_entry[23:16], 1'b1, r_entry[15:8], 1'b1, r_entry[7:0], 1'b1};
                        r_bits_left <= 5'd27;
                        r_q         <= 2'd1;
                    end else begin
                        r_scl   <= 1'b0;
                        r_q     <= 2'd0;
                        r_phase <= PH_DATA;
                    end
                end
                PH_DATA: begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0: r_sda_oe <= ~r_shift[26];
                        2'd1: r_scl <= 1'b1;
                        2'd2: if (w_ack_slot) r_nack <= r_nack | w_sda_in;
                        default: begin
                            r_scl       <= 1'b0;
                            r_shift     <= {r_shift[25:0], 1'b0};
                            r_bits_left <= r_bits_left - 5'd1;
                            if (r_bits_left == 5'd1) r_phase <= PH_STOP;
                        end
                    endcase
                end
                PH_STOP: begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0:    r_sda_oe <= 1'b1;
                        2'd1:    r_scl <= 1'b1;
                        default: r_sda_oe <= 1'b0;
                    endcase
                end
                default: r_phase <= PH_START;
            endcase
        end
    end

    assign I2C_SCLK   = r_scl;
    assign I2C_SDAT   = r_sda_oe ? 1'b0 : 1'bz;
    assign oROM_ADDR  = r_index;
    assign oBUSY      = w_busy;
    assign oDONE      = w_done;
    assign oERR       = w_err;
    assign oERR_INDEX = r_err_index;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Directed bench for i2c_cfg_seq: table ROM, I2C slave monitor/responder, one task per scenario.
module tb_i2c_cfg_seq;

    localparam int CLK_FREQ  = 400;
    localparam int I2C_FREQ  = 20;
    localparam int LUT_SIZE  = 16;
    localparam int ADDR_W    = 4;
    localparam int MAX_RETRY = 3;
    localparam int TICK_CYC  = 5;

    localparam logic [23:0] E0  = 24'h40_10_A5;
    localparam logic [23:0] E1  = 24'h42_20_5A;
    localparam logic [23:0] E2  = 24'h44_31_C3;
    localparam logic [23:0] EOT = 24'hFF_00_00;
    localparam logic [23:0] DLY = 24'hFE_00_10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data = '0;
    logic [23:0]       rom [0:LUT_SIZE-1];
    logic              scl;
    wire               sda;
    logic              slave_low = 1'b0;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_index;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Slave configuration, written only by the stimulus.
    int         nack_byte = -1;
    logic [7:0] nack_addr = 8'h00;
    int         nack_limit = 0;
    int         cfg_id = 0;

    // Monitor state, written only by the monitor.
    int          seen_cfg = 0;
    int          nack_given = 0;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    int          bit_cnt = 0;
    int          byte_cnt = 0;
    int          start_cnt = 0;
    int          stop_cnt = 0;
    int          xfer_cnt = 0;
    logic [7:0]  sh = '0;
    logic [7:0]  cur_addr = '0;
    logic [23:0] cur = '0;
    logic [23:0] xlog [0:63];
    int          start_cyc [0:63];
    int          stop_cyc [0:63];

    pullup(sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    i2c_cfg_seq #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ),
        .LUT_SIZE (LUT_SIZE),
        .ADDR_W   (ADDR_W),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iSTART    (start),
        .oROM_ADDR (rom_addr),
        .iROM_DATA (rom_data),
        .I2C_SCLK  (scl),
        .I2C_SDAT  (sda),
        .oBUSY     (busy),
        .oDONE     (done),
        .oERR      (err),
        .oERR_INDEX(err_index)
    );

    // Bus monitor and acking slave: detects START/STOP, shifts bits on SCL rise, acks on SCL fall.
    always @(negedge clk) begin : monitor
        logic sv;
        logic give_nack;
        sv = (sda !== 1'b0);
        if (seen_cfg != cfg_id) begin
            seen_cfg   = cfg_id;
            nack_given = 0;
        end
        if (prev_scl && scl && prev_sda && !sv) begin
            start_cyc[start_cnt % 64] = cyc;
            start_cnt++;
            bit_cnt  = 0;
            byte_cnt = 0;
        end else if (prev_scl && scl && !prev_sda && sv) begin
            stop_cyc[stop_cnt % 64] = cyc;
            stop_cnt++;
        end
        if (!prev_scl && scl) begin
            if (bit_cnt < 8) sh = {sh[6:0], sv};
            bit_cnt++;
        end else if (prev_scl && !scl) begin
            if (bit_cnt == 8) begin
                cur = {cur[15:0], sh};
                if (byte_cnt == 0) cur_addr = sh;
                if (byte_cnt == 2) begin
                    if (xfer_cnt < 64) xlog[xfer_cnt] = cur;
                    xfer_cnt++;
                end
                give_nack = (nack_byte >= 0) && (byte_cnt == nack_byte) && (cur_addr == nack_addr) &&
                            ((nack_limit < 0) || (nack_given < nack_limit));
                if (give_nack) nack_given++;
                slave_low = !give_nack;
            end else if (bit_cnt == 9) begin
                slave_low = 1'b0;
                bit_cnt   = 0;
                byte_cnt++;
            end
        end
        prev_scl = scl;
        prev_sda = sv;
    end

    task automatic set_slave(input int byte_sel, input logic [7:0] addr, input int limit);
        nack_byte  = byte_sel;
        nack_addr  = addr;
        nack_limit = limit;
        cfg_id++;
    endtask

    task automatic load_table(input logic [23:0] t0, input logic [23:0] t1,
                              input logic [23:0] t2, input logic [23:0] t3);
        rst_n = 1'b0;
        for (int i = 0; i < LUT_SIZE; i++) rom[i] = EOT;
        rom[0] = t0;
        rom[1] = t1;
        rom[2] = t2;
        rom[3] = t3;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string name);
        int n;
        n = 0;
        while (!(done || err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(done || err)) begin
            errors++;
            $display("FAIL %s_timeout: done/err still low after %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        set_slave(-1, 8'h00, 0);
        load_table(E0, E1, E2, EOT);
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want released", sda); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (err_index !== '0) begin errors++; $display("FAIL reset_err_index: got %0d want 0", err_index); end
        release_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL autostart_busy: got %b want 1", busy); end
    endtask

    task automatic test_basic_writes();
        int s0, st0, sp0;
        logic [23:0] exp [3];
        exp[0] = E0; exp[1] = E1; exp[2] = E2;
        set_slave(-1, 8'h00, 0);
        load_table(E0, E1, E2, EOT);
        s0 = xfer_cnt; st0 = start_cnt; sp0 = stop_cnt;
        release_reset();
        wait_end(6000, "basic");
        checks++; if (stop_cnt - sp0 !== 3) begin errors++; $display("FAIL basic_stops_at_done: got %0d want 3", stop_cnt - sp0); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
        checks++; if (xfer_cnt - s0 !== 3) begin errors++; $display("FAIL basic_xfers: got %0d want 3", xfer_cnt - s0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (xlog[s0 + i] !== exp[i]) begin
                errors++; $display("FAIL basic_bytes[%0d]: got %h want %h", i, xlog[s0 + i], exp[i]);
            end
        end
        repeat (1500) @(negedge clk);
        checks++; if (start_cnt - st0 !== 3) begin errors++; $display("FAIL basic_quiet_bus: got %0d starts want 3", start_cnt - st0); end
        checks++; if (scl !== 1'b1 || sda !== 1'b1) begin errors++; $display("FAIL basic_bus_idle: got scl=%b sda=%b want 1/1", scl, sda); end
    endtask

    task automatic test_retry();
        int s0;
        logic [23:0] exp [5];
        exp[0] = E0; exp[1] = E1; exp[2] = E1; exp[3] = E1; exp[4] = E2;
        set_slave(2, 8'h42, 2);
        load_table(E0, E1, E2, EOT);
        s0 = xfer_cnt;
        release_reset();
        wait_end(10000, "retry");
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL retry_done: got %b want 1", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL retry_err: got %b want 0", err); end
        checks++; if (xfer_cnt - s0 !== 5) begin errors++; $display("FAIL retry_xfers: got %0d want 5", xfer_cnt - s0); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (xlog[s0 + i] !== exp[i]) begin
                errors++; $display("FAIL retry_bytes[%0d]: got %h want %h", i, xlog[s0 + i], exp[i]);
            end
        end
    endtask

    task automatic test_fail_restart();
        int s0, st0;
        logic [23:0] exp [6];
        exp[0] = E0; exp[1] = E1; exp[2] = E2; exp[3] = E2; exp[4] = E2; exp[5] = E2;
        set_slave(0, 8'h44, -1);
        load_table(E0, E1, E2, EOT);
        s0 = xfer_cnt; st0 = start_cnt;
        release_reset();
        repeat (300) @(negedge clk);
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_while_busy: got busy=%b want 1", busy); end
        wait_end(12000, "fail");
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL fail_err: got %b want 1", err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fail_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fail_busy: got %b want 0", busy); end
        checks++; if (err_index !== 4'd2) begin errors++; $display("FAIL fail_err_index: got %0d want 2", err_index); end
        checks++; if (start_cnt - st0 !== 6) begin errors++; $display("FAIL fail_starts: got %0d want 6", start_cnt - st0); end
        checks++; if (scl !== 1'b1 || sda !== 1'b1) begin errors++; $display("FAIL fail_bus_idle: got scl=%b sda=%b want 1/1", scl, sda); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (xlog[s0 + i] !== exp[i]) begin
                errors++; $display("FAIL fail_bytes[%0d]: got %h want %h", i, xlog[s0 + i], exp[i]);
            end
        end
        set_slave(-1, 8'h00, 0);
        s0 = xfer_cnt;
        pulse_start();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL restart_err_clear: got %b want 0", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL restart_index: got %0d want 0", rom_addr); end
        wait_end(6000, "restart");
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", done); end
        checks++; if (xfer_cnt - s0 !== 3) begin errors++; $display("FAIL restart_xfers: got %0d want 3", xfer_cnt - s0); end
        checks++; if (xlog[s0] !== E0) begin errors++; $display("FAIL restart_first: got %h want %h", xlog[s0], E0); end
    endtask

    task automatic test_delay();
        int s0, st0, sp0, gap_ticks;
        set_slave(-1, 8'h00, 0);
        load_table(E0, DLY, E2, EOT);
        s0 = xfer_cnt; st0 = start_cnt; sp0 = stop_cnt;
        release_reset();
        wait_end(6000, "delay");
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL delay_done: got %b want 1", done); end
        checks++; if (xfer_cnt - s0 !== 2) begin errors++; $display("FAIL delay_xfers: got %0d want 2", xfer_cnt - s0); end
        checks++; if (xlog[s0 + 1] !== E2) begin errors++; $display("FAIL delay_second: got %h want %h", xlog[s0 + 1], E2); end
        gap_ticks = (start_cyc[(st0 + 1) % 64] - stop_cyc[sp0 % 64]) / TICK_CYC;
        checks++;
        if (gap_ticks < 14 || gap_ticks > 18) begin
            errors++; $display("FAIL delay_gap: got %0d ticks want 14..18", gap_ticks);
        end
    endtask

    task automatic test_reset_mid_byte();
        int s0, st0, n;
        logic [23:0] exp [3];
        exp[0] = E0; exp[1] = E1; exp[2] = E2;
        set_slave(-1, 8'h00, 0);
        load_table(E0, E1, E2, EOT);
        st0 = start_cnt;
        release_reset();
        n = 0;
        while (!(start_cnt > st0 && byte_cnt == 0 && bit_cnt == 4) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (scl !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (scl !== 1'b0 || sda !== 1'b0) begin errors++; $display("FAIL midbyte_precondition: got scl=%b sda=%b want 0/0", scl, sda); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL midbyte_reset_scl: got %b want 1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL midbyte_reset_sda: got %b want released", sda); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midbyte_reset_busy: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        s0 = xfer_cnt;
        release_reset();
        wait_end(6000, "midbyte");
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL midbyte_done: got %b want 1", done); end
        checks++; if (xfer_cnt - s0 !== 3) begin errors++; $display("FAIL midbyte_xfers: got %0d want 3", xfer_cnt - s0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (xlog[s0 + i] !== exp[i]) begin
                errors++; $display("FAIL midbyte_bytes[%0d]: got %h want %h", i, xlog[s0 + i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_writes();
        test_retry();
        test_fail_restart();
        test_delay();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
